// File: rtl/sr_input_conditioner_if.sv
// Button/command bundle between the push-button front end and its consumer.
// The master side drives the raw buttons and controls; the slave side returns the s/r commands and debug state.
interface sr_input_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             btn_set;
  logic             btn_rst;
  logic             en;
  logic             clr_flags;
  logic             s;
  logic             r;
  logic             conflict_sticky;
  logic [CNT_W-1:0] set_count;
  logic [CNT_W-1:0] rst_count;

  modport master (
    output btn_set, btn_rst, en, clr_flags,
    input  s, r, conflict_sticky, set_count, rst_count
  );

  modport slave (
    input  btn_set, btn_rst, en, clr_flags,
    output s, r, conflict_sticky, set_count, rst_count
  );
endinterface

// File: rtl/sr_input_conditioner.sv
// Synchronises, debounces and edge-detects two push-buttons into mutually exclusive
// single-cycle s/r commands for an SR flop, with saturating pulse counters and a sticky conflict flag.
module sr_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_WINS      = 1'b1,
  parameter int CNT_W           = 8
) (
  input logic                  clk,
  input logic                  reset,
  sr_input_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0] raw;  // [0] = set line, [1] = reset line
  logic [1:0] req;

  assign raw = {bus.btn_rst, bus.btn_set};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_out != stable_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_out;
        else                                   cnt_d    = cnt_q + 1'b1;
      end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts correctly.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
        prev_q   <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        prev_q   <= stable_q;
      end
    end

    // Only a debounced press (0->1) requests; release is silent.
    assign req[ch] = stable_q & ~prev_q;
  end

  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  always_comb begin
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = conflict_q;
    set_cnt_d  = set_cnt_q;
    rst_cnt_d  = rst_cnt_q;

    if (bus.en) begin
      if (req[0] && req[1]) begin
        if (RESET_WINS) r_d = 1'b1;
        else            s_d = 1'b1;
        conflict_d = 1'b1;
      end else begin
        s_d = req[0];
        r_d = req[1];
      end
      if (s_d && set_cnt_q != '1) set_cnt_d = set_cnt_q + 1'b1;
      if (r_d && rst_cnt_q != '1) rst_cnt_d = rst_cnt_q + 1'b1;
    end

    // Clearing overrides this cycle's increment/conflict, but s/r still go out.
    if (bus.clr_flags) begin
      conflict_d = 1'b0;
      set_cnt_d  = '0;
      rst_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      set_cnt_q  <= '0;
      rst_cnt_q  <= '0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      set_cnt_q  <= set_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign bus.s               = s_q;
  assign bus.r               = r_q;
  assign bus.conflict_sticky = conflict_q;
  assign bus.set_count       = set_cnt_q;
  assign bus.rst_count       = rst_cnt_q;
endmodule
